// File: rtl/pencere_uretici_pkg.sv
// Shared types for the 3x3 window producer: pixel/column payloads and window packing.
package pencere_uretici_pkg;

   localparam int unsigned PIXEL_BIT   = 8;
   localparam int unsigned PENCERE_BIT = 9 * PIXEL_BIT;

   typedef logic [PIXEL_BIT-1:0] pixel_t;

   typedef struct packed {
      pixel_t ust;
      pixel_t orta;
      pixel_t alt;
   } sutun_t;

   // Row-major packing, top-left pixel in the least significant byte
   function automatic logic [PENCERE_BIT-1:0] pencere_paketle(input sutun_t s0,
                                                              input sutun_t s1,
                                                              input sutun_t s2);
      return {s2.alt, s1.alt, s0.alt, s2.orta, s1.orta, s0.orta, s2.ust, s1.ust, s0.ust};
   endfunction

endpackage

// File: rtl/pencere_uretici_satir_tamponu.sv
// 1R1W line buffer, read and write share one address; the read sees the old word.
module pencere_uretici_satir_tamponu #(
   parameter  int unsigned DERINLIK = 320,
   parameter  int unsigned GENIS    = 16,
   localparam int unsigned ADRES_W  = $clog2(DERINLIK)
) (
   input  logic               clk_i,
   input  logic               i_yaz,
   input  logic [ADRES_W-1:0] i_adres,
   input  logic [GENIS-1:0]   i_veri,
   output logic [GENIS-1:0]   o_veri_c
);

   logic [GENIS-1:0] r_bellek [DERINLIK];

   always_ff @(posedge clk_i) begin
      if (i_yaz) begin
         r_bellek[i_adres] <= i_veri;
      end
   end

   assign o_veri_c = r_bellek[i_adres];

endmodule

// File: rtl/pencere_uretici.sv
// Raster pixel stream to 3x3 interior windows, stall-aware, with end-of-frame marker.
module pencere_uretici
   import pencere_uretici_pkg::*;
#(
   parameter int unsigned GENISLIK  = 320,
   parameter int unsigned YUKSEKLIK = 240
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   etkin_i,
   input  logic [PIXEL_BIT-1:0]   pixel_i,
   input  logic                   stal_i,
   output logic                   hazir_o,
   output logic                   etkin_o,
   output logic [PENCERE_BIT-1:0] pencere_o,
   output logic                   cerceve_son_o
);

   localparam int unsigned SUTUN_W  = $clog2(GENISLIK);
   localparam int unsigned SATIR_W  = $clog2(YUKSEKLIK);
   localparam int unsigned TAMPON_W = 2 * PIXEL_BIT;

   logic [SUTUN_W-1:0]  r_sutun;
   logic [SATIR_W-1:0]  r_satir;
   sutun_t              r_sol;
   sutun_t              r_orta;
   sutun_t              r_sag;
   logic                r_etkin;
   logic                r_son;

   logic                w_kabul;
   logic                w_sutun_son;
   logic                w_satir_son;
   logic                w_ic;
   logic [TAMPON_W-1:0] w_tampon;
   sutun_t              w_yeni;

   assign w_kabul     = etkin_i & ~stal_i;
   assign w_sutun_son = (r_sutun == SUTUN_W'(GENISLIK - 1));
   assign w_satir_son = (r_satir == SATIR_W'(YUKSEKLIK - 1));
   assign w_ic        = (r_satir >= SATIR_W'(2)) && (r_sutun >= SUTUN_W'(2));

   // Upper half holds line r-2, lower half line r-1
   assign w_yeni = '{ust:  w_tampon[TAMPON_W-1:PIXEL_BIT],
                     orta: w_tampon[PIXEL_BIT-1:0],
                     alt:  pixel_i};

   pencere_uretici_satir_tamponu #(
      .DERINLIK (GENISLIK),
      .GENIS    (TAMPON_W)
   ) u_tampon (
      .clk_i    (clk_i),
      .i_yaz    (w_kabul),
      .i_adres  (r_sutun),
      .i_veri   ({w_tampon[PIXEL_BIT-1:0], pixel_i}),
      .o_veri_c (w_tampon)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sutun <= '0;
         r_satir <= '0;
         r_sol   <= '0;
         r_orta  <= '0;
         r_sag   <= '0;
         r_etkin <= 1'b0;
         r_son   <= 1'b0;
      end else if (w_kabul) begin
         r_sol   <= r_orta;
         r_orta  <= r_sag;
         r_sag   <= w_yeni;
         r_etkin <= w_ic;
         r_son   <= w_satir_son & w_sutun_son;
         if (w_sutun_son) begin
            r_sutun <= '0;
            r_satir <= w_satir_son ? '0 : r_satir + SATIR_W'(1);
         end else begin
            r_sutun <= r_sutun + SUTUN_W'(1);
         end
      end else if (!stal_i) begin
         // Idle, unstalled cycle: the held window has been consumed
         r_etkin <= 1'b0;
         r_son   <= 1'b0;
      end
   end

   assign hazir_o       = ~stal_i;
   assign etkin_o       = r_etkin;
   assign pencere_o     = pencere_paketle(r_sol, r_orta, r_sag);
   assign cerceve_son_o = r_son;

endmodule

// File: tb/tb_pencere_uretici.sv
// Bench for pencere_uretici: directed 4x4 frames plus randomized 4x4 and 320x240 runs against an image model.
module tb_pencere_uretici;
   import pencere_uretici_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        etkin_i;
   logic        stal_i;
   logic [7:0]  pixel_i;

   logic        k_hazir, k_etkin, k_son;
   logic [71:0] k_pencere;
   logic        b_hazir, b_etkin, b_son;
   logic [71:0] b_pencere;

   int          checks   = 0;
   int          failures = 0;

   int          mW = 4;
   int          mH = 4;
   int          m_idx;
   logic [7:0]  img [76800];
   logic        m_etkin;
   logic        m_son;
   logic [71:0] m_pencere;

   localparam logic [71:0] ILK_PENCERE  = 72'h0A_09_08_06_05_04_02_01_00;
   localparam logic [71:0] SON_PENCERE  = 72'h0F_0E_0D_0B_0A_09_07_06_05;
   localparam logic [71:0] ILK_PENCERE2 = 72'h1A_19_18_16_15_14_12_11_10;

   always #5 clk = ~clk;

   pencere_uretici #(.GENISLIK(4), .YUKSEKLIK(4)) u_kucuk (
      .clk_i(clk), .rst_i(rst), .etkin_i(etkin_i), .pixel_i(pixel_i), .stal_i(stal_i),
      .hazir_o(k_hazir), .etkin_o(k_etkin), .pencere_o(k_pencere), .cerceve_son_o(k_son));

   pencere_uretici #(.GENISLIK(320), .YUKSEKLIK(240)) u_buyuk (
      .clk_i(clk), .rst_i(rst), .etkin_i(etkin_i), .pixel_i(pixel_i), .stal_i(stal_i),
      .hazir_o(b_hazir), .etkin_o(b_etkin), .pencere_o(b_pencere), .cerceve_son_o(b_son));

   task automatic model_sifirla();
      m_idx     = 0;
      m_etkin   = 1'b0;
      m_son     = 1'b0;
      m_pencere = '0;
   endtask

   // One clock: drive inputs, advance the image model, return #1 after the edge
   task automatic adim(input logic e, input logic s, input logic [7:0] p);
      int r, c;
      @(negedge clk);
      etkin_i = e;
      stal_i  = s;
      pixel_i = p;
      if (e && !s) begin
         r = m_idx / mW;
         c = m_idx % mW;
         img[r*mW + c] = p;
         m_etkin = (r >= 2) && (c >= 2);
         if (m_etkin) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  m_pencere[(i*3 + j)*8 +: 8] = img[(r-2+i)*mW + (c-2+j)];
         end
         m_son = (r == mH-1) && (c == mW-1);
         m_idx = (m_idx + 1 == mW*mH) ? 0 : m_idx + 1;
      end else if (!s) begin
         m_etkin = 1'b0;
         m_son   = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sifirla();
      @(negedge clk);
      etkin_i = 1'b0;
      stal_i  = 1'b0;
      rst     = 1'b1;
      model_sifirla();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; etkin_i = 1'b0; stal_i = 1'b0; pixel_i = '0;
      model_sifirla();
      #1;
      checks++; if (k_etkin !== 1'b0) begin failures++; $display("FAIL reset_etkin got=%b exp=0", k_etkin); end
      checks++; if (k_son !== 1'b0) begin failures++; $display("FAIL reset_son got=%b exp=0", k_son); end
      checks++; if (k_pencere !== 72'h0) begin failures++; $display("FAIL reset_pencere got=%h exp=0", k_pencere); end
      checks++; if (b_etkin !== 1'b0 || b_pencere !== 72'h0) begin failures++; $display("FAIL reset_buyuk got=%b/%h exp=0/0", b_etkin, b_pencere); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_tam_cerceve();
      int n = 0;
      mW = 4; mH = 4;
      sifirla();
      for (int i = 0; i < 16; i++) begin
         adim(1'b1, 1'b0, 8'(i));
         checks++; if (k_hazir !== 1'b1) begin failures++; $display("FAIL tam_hazir px=%0d got=%b exp=1", i, k_hazir); end
         checks++; if (k_etkin !== m_etkin) begin failures++; $display("FAIL tam_etkin px=%0d got=%b exp=%b", i, k_etkin, m_etkin); end
         checks++; if (k_son !== m_son) begin failures++; $display("FAIL tam_son px=%0d got=%b exp=%b", i, k_son, m_son); end
         if (m_etkin) begin
            checks++; if (k_pencere !== m_pencere) begin failures++; $display("FAIL tam_pencere px=%0d got=%h exp=%h", i, k_pencere, m_pencere); end
         end
         if (k_etkin === 1'b1) n++;
         if (i == 10) begin
            checks++; if (k_pencere !== ILK_PENCERE) begin failures++; $display("FAIL tam_ilk got=%h exp=%h", k_pencere, ILK_PENCERE); end
         end
         if (i == 15) begin
            checks++; if (k_pencere !== SON_PENCERE || k_son !== 1'b1) begin failures++; $display("FAIL tam_son_pencere got=%h/%b exp=%h/1", k_pencere, k_son, SON_PENCERE); end
         end
      end
      adim(1'b0, 1'b0, 8'h0);
      checks++; if (k_etkin !== 1'b0 || k_son !== 1'b0) begin failures++; $display("FAIL tam_bosta got=%b/%b exp=0/0", k_etkin, k_son); end
      checks++; if (n != 4) begin failures++; $display("FAIL tam_sayi got=%0d exp=4", n); end
   endtask

   task automatic test_stall();
      int n = 0;
      mW = 4; mH = 4;
      sifirla();
      for (int i = 0; i < 16; i++) begin
         adim(1'b1, 1'b0, 8'(i));
         if (k_etkin === 1'b1) n++;
         checks++; if (k_etkin !== m_etkin || (m_etkin && k_pencere !== m_pencere)) begin failures++; $display("FAIL stall_akis px=%0d got=%b/%h exp=%b/%h", i, k_etkin, k_pencere, m_etkin, m_pencere); end
         if (i == 10) begin
            for (int k = 0; k < 3; k++) begin
               adim(1'b1, 1'b1, 8'($urandom));
               if (k_etkin === 1'b1) n++;
               checks++; if (k_hazir !== 1'b0) begin failures++; $display("FAIL stall_hazir k=%0d got=%b exp=0", k, k_hazir); end
               checks++; if (k_etkin !== 1'b1 || k_pencere !== ILK_PENCERE) begin failures++; $display("FAIL stall_tut k=%0d got=%b/%h exp=1/%h", k, k_etkin, k_pencere, ILK_PENCERE); end
            end
         end
      end
      checks++; if (n != 7) begin failures++; $display("FAIL stall_sayi got=%0d exp=7", n); end
   endtask

   task automatic test_bosluk();
      int   n = 0;
      logic onceki = 1'b0;
      mW = 4; mH = 4;
      sifirla();
      for (int i = 0; i < 16; i++) begin
         adim(1'b1, 1'b0, 8'(i));
         checks++; if (k_etkin !== m_etkin || (m_etkin && k_pencere !== m_pencere) || k_son !== m_son) begin failures++; $display("FAIL bosluk_akis px=%0d got=%b/%h exp=%b/%h", i, k_etkin, k_pencere, m_etkin, m_pencere); end
         checks++; if (onceki && k_etkin) begin failures++; $display("FAIL bosluk_ardisik px=%0d got=1 exp=0", i); end
         if (k_etkin === 1'b1) n++;
         onceki = k_etkin;
         adim(1'b0, 1'b0, 8'($urandom));
         checks++; if (k_etkin !== 1'b0) begin failures++; $display("FAIL bosluk_bos px=%0d got=%b exp=0", i, k_etkin); end
         onceki = k_etkin;
      end
      checks++; if (n != 4) begin failures++; $display("FAIL bosluk_sayi got=%0d exp=4", n); end
   endtask

   task automatic test_reset_ortasi();
      int n = 0;
      mW = 4; mH = 4;
      sifirla();
      for (int i = 0; i < 8; i++) adim(1'b1, 1'b0, 8'(i));
      #2 rst = 1'b1;
      #1;
      checks++; if (k_etkin !== 1'b0 || k_son !== 1'b0 || k_pencere !== 72'h0) begin failures++; $display("FAIL rst_orta got=%b/%b/%h exp=0/0/0", k_etkin, k_son, k_pencere); end
      model_sifirla();
      etkin_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         adim(1'b1, 1'b0, 8'(i));
         if (k_etkin === 1'b1) n++;
         if (i == 10) begin
            checks++; if (k_etkin !== 1'b1 || k_pencere !== ILK_PENCERE) begin failures++; $display("FAIL rst_ilk got=%b/%h exp=1/%h", k_etkin, k_pencere, ILK_PENCERE); end
         end
         if (i == 15) begin
            checks++; if (k_pencere !== SON_PENCERE || k_son !== 1'b1) begin failures++; $display("FAIL rst_son got=%h/%b exp=%h/1", k_pencere, k_son, SON_PENCERE); end
         end
      end
      checks++; if (n != 4) begin failures++; $display("FAIL rst_sayi got=%0d exp=4", n); end
   endtask

   task automatic test_back_to_back();
      int n = 0, s = 0;
      mW = 4; mH = 4;
      sifirla();
      for (int i = 0; i < 32; i++) begin
         adim(1'b1, 1'b0, 8'(i));
         checks++; if (k_etkin !== m_etkin || (m_etkin && k_pencere !== m_pencere) || k_son !== m_son) begin failures++; $display("FAIL b2b_akis px=%0d got=%b/%h/%b exp=%b/%h/%b", i, k_etkin, k_pencere, k_son, m_etkin, m_pencere, m_son); end
         if (k_etkin === 1'b1) n++;
         if (k_son === 1'b1) s++;
         if (i >= 16 && k_etkin === 1'b1) begin
            for (int b = 0; b < 9; b++) begin
               checks++; if (k_pencere[b*8 +: 8] < 8'd16) begin failures++; $display("FAIL b2b_sizinti px=%0d bayt=%0d got=%h exp>=10", i, b, k_pencere[b*8 +: 8]); end
            end
         end
         if (i == 26) begin
            checks++; if (k_pencere !== ILK_PENCERE2) begin failures++; $display("FAIL b2b_ilk2 got=%h exp=%h", k_pencere, ILK_PENCERE2); end
         end
      end
      checks++; if (n != 8 || s != 2) begin failures++; $display("FAIL b2b_sayi got=%0d/%0d exp=8/2", n, s); end
   endtask

   task automatic test_rastgele_kucuk();
      logic e, s;
      mW = 4; mH = 4;
      sifirla();
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 9) < 7);
         s = ($urandom_range(0, 9) < 2);
         adim(e, s, 8'($urandom));
         checks++; if (k_hazir !== !s) begin failures++; $display("FAIL rnd_hazir cyc=%0d got=%b exp=%b", i, k_hazir, !s); end
         checks++; if (k_etkin !== m_etkin || k_son !== m_son) begin failures++; $display("FAIL rnd_etkin cyc=%0d got=%b/%b exp=%b/%b", i, k_etkin, k_son, m_etkin, m_son); end
         if (m_etkin) begin
            checks++; if (k_pencere !== m_pencere) begin failures++; $display("FAIL rnd_pencere cyc=%0d got=%h exp=%h", i, k_pencere, m_pencere); end
         end
      end
   endtask

   task automatic test_buyuk();
      int n = 0, s = 0;
      mW = 320; mH = 240;
      sifirla();
      for (int i = 0; i < 320*240; i++) begin
         adim(1'b1, 1'b0, 8'($urandom));
         checks++; if (b_etkin !== m_etkin || b_son !== m_son) begin failures++; $display("FAIL buyuk_etkin px=%0d got=%b/%b exp=%b/%b", i, b_etkin, b_son, m_etkin, m_son); end
         if (m_etkin) begin
            checks++; if (b_pencere !== m_pencere) begin failures++; $display("FAIL buyuk_pencere px=%0d got=%h exp=%h", i, b_pencere, m_pencere); end
         end
         if (b_etkin === 1'b1) n++;
         if (b_son === 1'b1) s++;
      end
      checks++; if (n != 318*238 || s != 1) begin failures++; $display("FAIL buyuk_sayi got=%0d/%0d exp=%0d/1", n, s, 318*238); end
   endtask

   initial begin
      test_reset();
      test_tam_cerceve();
      test_stall();
      test_bosluk();
      test_reset_ortasi();
      test_back_to_back();
      test_rastgele_kucuk();
      test_buyuk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
